// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
package button_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_CHK,
      HELD,
      LONG,
      RELEASE_CHK
   } cond_state_e;

   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
   localparam int unsigned DEF_LONG_CYCLES     = 64;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous bit; clears to 0 on reset.
module bit_synchronizer #(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Turns a bouncing push-button into clean press/release/long-press pulses
// and a debounced level for the RGB sequencer.
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_button_raw,
   output logic o_press,
   output logic o_release,
   output logic o_long_press,
   output logic o_held
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES);
   localparam logic [LW-1:0] L_MAX = LW'(LONG_CYCLES);

   logic w_s;

   cond_state_e r_state, w_state_nxt;
   logic [DW-1:0] r_dcnt, w_dcnt_nxt, w_dcnt_inc;
   logic [LW-1:0] r_lcnt, w_lcnt_nxt, w_lcnt_inc;
   logic r_long_done, w_long_done_nxt;
   logic r_press, w_press_nxt;
   logic r_release, w_release_nxt;
   logic r_long_press, w_long_press_nxt;
   logic r_held, w_held_nxt;
   logic w_long_hit;

   bit_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_d       (i_button_raw),
      .o_q       (w_s)
   );

   assign w_dcnt_inc = (r_dcnt == D_MAX) ? r_dcnt : r_dcnt + DW'(1);
   assign w_lcnt_inc = (r_lcnt == L_MAX) ? r_lcnt : r_lcnt + LW'(1);
   // Long timer fires once per press, whether still held or mid release-debounce
   assign w_long_hit = (w_lcnt_inc == L_MAX) && !r_long_done;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= IDLE;
         r_dcnt       <= '0;
         r_lcnt       <= '0;
         r_long_done  <= 1'b0;
         r_press      <= 1'b0;
         r_release    <= 1'b0;
         r_long_press <= 1'b0;
         r_held       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_dcnt       <= w_dcnt_nxt;
         r_lcnt       <= w_lcnt_nxt;
         r_long_done  <= w_long_done_nxt;
         r_press      <= w_press_nxt;
         r_release    <= w_release_nxt;
         r_long_press <= w_long_press_nxt;
         r_held       <= w_held_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_dcnt_nxt       = r_dcnt;
      w_lcnt_nxt       = r_lcnt;
      w_long_done_nxt  = r_long_done;
      w_press_nxt      = 1'b0;
      w_release_nxt    = 1'b0;
      w_long_press_nxt = 1'b0;
      w_held_nxt       = r_held;

      case (r_state)
         IDLE: begin
            if (w_s) begin
               w_state_nxt = PRESS_CHK;
               w_dcnt_nxt  = DW'(1);
            end
         end

         PRESS_CHK: begin
            if (!w_s) begin
               w_state_nxt = IDLE;
               w_dcnt_nxt  = '0;
            end else if (r_dcnt == D_MAX) begin
               w_state_nxt     = HELD;
               w_press_nxt     = 1'b1;
               w_held_nxt      = 1'b1;
               w_lcnt_nxt      = '0;
               w_long_done_nxt = 1'b0;
            end else begin
               w_dcnt_nxt = w_dcnt_inc;
            end
         end

         HELD: begin
            w_lcnt_nxt = w_lcnt_inc;
            if (w_long_hit) begin
               w_long_press_nxt = 1'b1;
               w_long_done_nxt  = 1'b1;
               w_state_nxt      = LONG;
            end
            if (!w_s) begin
               w_state_nxt = RELEASE_CHK;
               w_dcnt_nxt  = DW'(1);
            end
         end

         LONG: begin
            if (!w_s) begin
               w_state_nxt = RELEASE_CHK;
               w_dcnt_nxt  = DW'(1);
            end
         end

         RELEASE_CHK: begin
            w_lcnt_nxt = w_lcnt_inc;
            if (w_long_hit) begin
               w_long_press_nxt = 1'b1;
               w_long_done_nxt  = 1'b1;
            end
            if (w_s) begin
               w_state_nxt = w_long_done_nxt ? LONG : HELD;
               w_dcnt_nxt  = '0;
            end else if (r_dcnt == D_MAX) begin
               w_state_nxt   = IDLE;
               w_release_nxt = 1'b1;
               w_held_nxt    = 1'b0;
            end else begin
               w_dcnt_nxt = w_dcnt_inc;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign o_press      = r_press;
   assign o_release    = r_release;
   assign o_long_press = r_long_press;
   assign o_held       = r_held;

endmodule
